dmem_responder: RTL and testbench

Responder end of the uPOWER load/store data-memory interface: accepts `ld`/`std` doubleword requests from the processor's memory stage over a valid/ready handshake, services them against an internal doubleword array after a programmable number of wait states, and returns read data and an error flag over a second valid/ready handshake. It replaces the zero-latency data memory when the datapath moves to a multi-cycle or stalled memory stage.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// doubleword geometry and the latched request record.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAITING,
      RESP
   } dmem_state_t;

   localparam int          DW_BYTES   = 8;
   localparam logic [63:0] ALIGN_MASK = 64'(DW_BYTES - 1);

   typedef struct packed {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage with one synchronous write port and one synchronous
// read port; both act only on the cycle the responder performs an access.
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we)
            mem[idx] <= wdata;
         else
            rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the ld/std data-memory handshake: accepts one request,
// waits WAIT cycles, performs the access and holds the response until taken.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int         AW        = $clog2(DEPTH);
   localparam bit         NO_WAIT   = (WAIT == 0);
   localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT - 1);

   dmem_state_t state;
   dmem_req_t   req_q;
   logic        err_q;
   logic [3:0]  cnt;
   logic        rd_valid;
   logic        err_out;

   logic        req_err;
   logic        access;
   dmem_req_t   acc_req;
   logic        acc_err;
   logic [63:0] arr_rdata;

   assign req_err = (|(req_addr & ALIGN_MASK)) || (req_addr[63:3] >= 61'(DEPTH));

   // With no wait states the access happens on the accept edge, so the array
   // must see the live request instead of the latched copy.
   always_comb begin
      acc_req = req_q;
      acc_err = err_q;
      access  = 1'b0;
      if (state == IDLE) begin
         acc_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
         acc_err = req_err;
         access  = NO_WAIT && req_valid && !rst;
      end else if (state == WAITING) begin
         access  = (cnt == 4'd0) && !rst;
      end
   end

   dmem_array #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_array (
      .clk  (clk),
      .en   (access && !acc_err),
      .we   (acc_req.we),
      .idx  (acc_req.addr[AW+2:3]),
      .wdata(acc_req.wdata),
      .rdata(arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req_q    <= '0;
         err_q    <= 1'b0;
         cnt      <= 4'd0;
         rd_valid <= 1'b0;
         err_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                  err_q <= req_err;
                  if (NO_WAIT) begin
                     state    <= RESP;
                     rd_valid <= !req_we && !req_err;
                     err_out  <= req_err;
                  end else begin
                     state <= WAITING;
                     cnt   <= WAIT_LOAD;
                  end
               end
            end
            WAITING: begin
               if (cnt == 4'd0) begin
                  state    <= RESP;
                  rd_valid <= !req_q.we && !err_q;
                  err_out  <= err_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state    <= IDLE;
                  rd_valid <= 1'b0;
                  err_out  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);
   assign resp_err   = err_out;
   // The array read register only updates on load accesses; rd_valid masks it
   // so stores, errors and reset all present zero.
   assign resp_rdata = rd_valid ? arr_rdata : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one WAIT=2 instance and one WAIT=0
// instance, checked against a plain array model of the memory.
module tb_dmem_responder;

   localparam int DEPTHS[2] = '{256, 16};
   localparam int WAITS[2]  = '{2, 0};

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [63:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [63:0] resp_rdata [2];
   logic        resp_err   [2];
   logic        busy       [2];

   logic [63:0] model_mem [2][256];
   int tests_run = 0;
   int fail_count = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .WAIT(2)) dut_w2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
   );

   dmem_responder #(.DEPTH(16), .WAIT(0)) dut_w0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_idle_outputs(input int d, input string tag);
      check($sformatf("d%0d_%s_req_ready", d, tag), 64'(req_ready[d]), 64'd1);
      check($sformatf("d%0d_%s_resp_valid", d, tag), 64'(resp_valid[d]), 64'd0);
      check($sformatf("d%0d_%s_resp_rdata", d, tag), resp_rdata[d], 64'd0);
      check($sformatf("d%0d_%s_resp_err", d, tag), 64'(resp_err[d]), 64'd0);
      check($sformatf("d%0d_%s_busy", d, tag), 64'(busy[d]), 64'd0);
   endtask

   // One full request/response. hold = cycles resp_ready is kept low in RESP,
   // during which a stray store to address 0 is offered and must be ignored.
   task automatic txn(input int d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input int hold);
      logic        exp_err;
      logic [63:0] exp_rdata;
      logic [63:0] held_rdata;
      logic        held_err;
      int n;
      int low_cnt;
      exp_err   = (addr % 8 != 0) || (addr / 8 >= 64'(DEPTHS[d]));
      exp_rdata = 64'd0;
      if (!we && !exp_err) exp_rdata = model_mem[d][addr / 8];

      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         check($sformatf("d%0d_ready_timeout", d), 64'd0, 64'd1);
         return;
      end

      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_addr[d]   = addr;
      req_wdata[d]  = wdata;
      resp_ready[d] = (hold == 0);
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_addr[d]  = 64'($urandom);

      low_cnt = 0;
      for (n = 1; n <= 40; n++) begin
         if (!req_ready[d]) low_cnt++;
         if (resp_valid[d]) break;
         @(negedge clk);
      end
      check($sformatf("d%0d_resp_seen", d), 64'(resp_valid[d]), 64'd1);
      if (!resp_valid[d]) return;
      check($sformatf("d%0d_latency", d), 64'(n), 64'(WAITS[d] + 1));
      check($sformatf("d%0d_ready_low_cycles", d), 64'(low_cnt), 64'(n));
      check($sformatf("d%0d_busy_in_resp", d), 64'(busy[d]), 64'd1);
      check($sformatf("d%0d_rdata_a%0h", d, addr), resp_rdata[d], exp_rdata);
      check($sformatf("d%0d_err_a%0h", d, addr), 64'(resp_err[d]), 64'(exp_err));

      held_rdata = resp_rdata[d];
      held_err   = resp_err[d];
      for (int h = 0; h < hold; h++) begin
         req_valid[d] = 1'b1;
         req_we[d]    = 1'b1;
         req_addr[d]  = 64'd0;
         req_wdata[d] = 64'hDEAD_BEEF_0BAD_F00D;
         @(negedge clk);
         check($sformatf("d%0d_hold%0d_valid", d, h), 64'(resp_valid[d]), 64'd1);
         check($sformatf("d%0d_hold%0d_rdata", d, h), resp_rdata[d], held_rdata);
         check($sformatf("d%0d_hold%0d_err", d, h), 64'(resp_err[d]), 64'(held_err));
         check($sformatf("d%0d_hold%0d_req_ready", d, h), 64'(req_ready[d]), 64'd0);
      end
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b1;
      @(negedge clk);
      check($sformatf("d%0d_back_to_idle", d), 64'(req_ready[d]), 64'd1);
      check($sformatf("d%0d_valid_dropped", d), 64'(resp_valid[d]), 64'd0);

      if (we && !exp_err) model_mem[d][addr / 8] = wdata;
   endtask

   task automatic rand_txn(input int d);
      logic        we;
      logic [63:0] addr;
      int kind;
      we   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      addr = 64'($urandom_range(0, DEPTHS[d] - 1)) * 8;
      if (kind == 0) addr = addr + 64'($urandom_range(1, 7));
      if (kind == 1) addr = 64'(DEPTHS[d]) * 8 + 64'($urandom_range(0, 3)) * 8;
      if (kind == 2) addr = {32'($urandom), 32'($urandom)} | 64'h8000_0000_0000_0000;
      txn(d, we, addr, {32'($urandom), 32'($urandom)}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_we[d]     = 1'b0;
         req_addr[d]   = 64'd0;
         req_wdata[d]  = 64'd0;
         resp_ready[d] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs(0, "reset");
      check_idle_outputs(1, "reset");

      // Give every word a known random value so the model never depends on power-up contents.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTHS[d]; i++)
            txn(d, 1'b1, 64'(i) * 8, {32'($urandom), 32'($urandom)}, 0);

      txn(0, 1'b1, 64'h10, 64'h8, 0);
      txn(0, 1'b0, 64'h10, 64'h0, 0);

      txn(0, 1'b0, 64'h0C, 64'h0, 0);
      txn(0, 1'b0, 64'h08, 64'h0, 0);

      txn(0, 1'b1, 64'(DEPTHS[0]) * 8, 64'h1234_5678_9ABC_DEF0, 0);
      txn(0, 1'b0, 64'h0, 64'h0, 0);

      txn(0, 1'b0, 64'h10, 64'h0, 5);
      txn(0, 1'b0, 64'h0, 64'h0, 0);

      // Reset while a store sits in WAITING: the store must be dropped.
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 64'h20;
      req_wdata[0] = 64'hFFFF;
      @(negedge clk);
      req_valid[0] = 1'b0;
      check("d0_waiting_busy", 64'(busy[0]), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs(0, "midrst");
      repeat (3) @(negedge clk);
      check("d0_no_resp_after_rst", 64'(resp_valid[0]), 64'd0);
      txn(0, 1'b0, 64'h20, 64'h0, 0);

      txn(1, 1'b1, 64'h18, 64'hCAFE_F00D_1234_5678, 0);
      txn(1, 1'b0, 64'h18, 64'h0, 0);
      txn(1, 1'b0, 64'h18, 64'h0, 3);

      for (int k = 0; k < 40; k++) rand_txn(0);
      for (int k = 0; k < 30; k++) rand_txn(1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
